// File: rtl/sq_root_param_if.sv
// ---------------------------------------------------------------------------
// sq_root_param_if
// Streaming handshake bundle for the sq_root_param square-root unit.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and its data
// stable until that edge. The consumer may raise or drop ready freely.
// ready seen before valid has no effect.
//
// Signals:
//   in_valid / in_ready   operand channel (num, round_en)
//   num                   WIDTH-bit unsigned radicand
//   round_en              1 = round the root to nearest for this operand
//   out_valid / out_ready result channel (root, rem)
//   root                  RES_W+1-bit root (MSB set only when rounding overflows)
//   rem                   RES_W+1-bit remainder num - floor_root^2
//
// Modports:
//   master  producer/consumer side (drives operands, accepts results)
//   slave   the square-root unit
// ---------------------------------------------------------------------------
interface sq_root_param_if #(
   parameter int WIDTH = 16
);
   localparam int RES_W = WIDTH / 2;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] num;
   logic             round_en;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W:0]   root;
   logic [RES_W:0]   rem;

   modport master (
      output in_valid, num, round_en, out_ready,
      input  in_ready, out_valid, root, rem
   );

   modport slave (
      input  in_valid, num, round_en, out_ready,
      output in_ready, out_valid, root, rem
   );
endinterface

// File: rtl/sq_root_param.sv
// ---------------------------------------------------------------------------
// sq_root_param
// Sequential integer square root, one result digit per clock. Computes
// floor(sqrt(num)) and the remainder num - floor_root^2, with optional
// round-to-nearest of the root chosen per operand. Latency from the accept
// edge to out_valid is RES_W+1 edges, independent of the operand. Only one
// operand is in flight at a time.
//
// Ports:
//   clk        rising-edge system clock
//   reset      synchronous, active-high; discards any operation in progress
//   bus        sq_root_param_if.slave handshake bundle (operand and result)
//   busy       high whenever the unit is not idle
//   state_dbg  current FSM state (IDLE=0, ITER=1, ROUND=2, DONE=3)
//
// WIDTH must be even and at least 4, and must match the WIDTH of the
// connected interface.
// ---------------------------------------------------------------------------
module sq_root_param #(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   sq_root_param_if.slave        bus,
   output logic                  busy,
   output logic [1:0]            state_dbg
);
   localparam int RES_W = WIDTH / 2;
   localparam int CNT_W = $clog2(RES_W + 1);
   // Highest power of four representable in a WIDTH-bit operand.
   localparam logic [WIDTH:0] BIT_INIT = (WIDTH+1)'(1) << (WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   // One bit wider than the operand so res + bit can never wrap.
   logic [WIDTH:0]   num_r;
   logic [WIDTH:0]   res_r;
   logic [WIDTH:0]   bit_r;
   logic             rnd_r;
   logic [CNT_W-1:0] cnt;
   logic [RES_W:0]   root_r;
   logic [RES_W:0]   rem_r;

   logic [WIDTH:0]   trial;
   logic             round_up;

   assign trial = res_r + bit_r;
   // After the last digit num_r holds num - r^2. num > r^2 + r is exactly
   // the condition sqrt(num) > r + 0.5 for integer num.
   assign round_up = rnd_r && (num_r > res_r);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         num_r  <= '0;
         res_r  <= '0;
         bit_r  <= '0;
         rnd_r  <= 1'b0;
         cnt    <= '0;
         root_r <= '0;
         rem_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  num_r <= {1'b0, bus.num};
                  res_r <= '0;
                  bit_r <= BIT_INIT;
                  rnd_r <= bus.round_en;
                  cnt   <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               if (num_r >= trial) begin
                  num_r <= num_r - trial;
                  res_r <= (res_r >> 1) + bit_r;
               end else begin
                  res_r <= res_r >> 1;
               end
               bit_r <= bit_r >> 2;
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_W'(RES_W - 1)) begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               // Rounding up the largest root gives 2^RES_W, hence the
               // extra output bit.
               root_r <= res_r[RES_W:0] + {{RES_W{1'b0}}, round_up};
               // The remainder never exceeds 2*root, so RES_W+1 bits hold it.
               rem_r  <= num_r[RES_W:0];
               state  <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Status outputs decode the state register only; nothing here is
   // combinational from an input.
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.root      = root_r;
   assign bus.rem       = rem_r;
   assign busy          = (state != IDLE);
   assign state_dbg     = state;

endmodule
